// File: rtl/mux_pkg.sv
// Shared definitions for the MUX serial path.
//   - default geometry of the frame sequencer
//   - frame sequencer state encoding
//   - command record {chan, data, length} at the default geometry
//   - watchdogLast: last watchdog count still tolerated in SHIFT
package mux_pkg;

    localparam int unsigned DEF_CNT_WIDTH  = 3;
    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_CHAN_WIDTH = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ARM,
        ST_SHIFT,
        ST_DONE
    } mux_state_e;

    typedef struct packed {
        logic [DEF_CHAN_WIDTH-1:0] chan;
        logic [DEF_DATA_WIDTH-1:0] data;
        logic [DEF_CNT_WIDTH-1:0]  length;
    } MUX_CMD_T;

    // A frame of maximum length keeps the counter busy for 2**cntWidth-1
    // SHIFT cycles; busy still high on the 2**cntWidth-th cycle is a fault.
    function automatic int unsigned watchdogLast(input int unsigned cntWidth);
        return (32'd1 << cntWidth) - 32'd1;
    endfunction

endpackage

// File: rtl/mux_shift_reg.sv
// Payload shift register for the MUX serial path.
//   CLK       in   system clock, rising edge
//   RSTn      in   asynchronous active-low reset
//   load      in   parallel load of loadData (wins over shiftEn)
//   loadData  in   WIDTH-bit payload
//   shiftEn   in   shift left by one, zero fill
//   msb       out  current most significant bit
module mux_shift_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             load,
    input  logic [WIDTH-1:0] loadData,
    input  logic             shiftEn,
    output logic             msb
);

    logic [WIDTH-1:0] shreg;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= loadData;
        end else if (shiftEn) begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = shreg[WIDTH-1];

endmodule

// File: rtl/mux_frame_sequencer.sv
// Frame sequencer in front of the MUX bit counter.
// Takes one command per valid/ready handshake, loads its length into the
// counter, shifts the payload out MSB-first while the counter is busy and
// closes the frame with a one-cycle done pulse. A busy response that
// contradicts the commanded length, or a SHIFT phase that outlasts the
// longest legal frame, raises the sticky error flag.
//   CLK, RSTn        clock / asynchronous active-low reset
//   cmdValid/Ready   command handshake
//   cmdChannel/Data/Length   command fields
//   cntDataOut, cntLoad, cntClockEnable, cntBusy   bit counter interface
//   chanSel, chanEnable   MUX channel control
//   serialOut        serial data bit
//   done, error      frame complete pulse / sticky mismatch flag
module mux_frame_sequencer
    import mux_pkg::*;
#(
    parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned CHAN_WIDTH = DEF_CHAN_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic                  cmdValid,
    output logic                  cmdReady,
    input  logic [CHAN_WIDTH-1:0] cmdChannel,
    input  logic [DATA_WIDTH-1:0] cmdData,
    input  logic [CNT_WIDTH-1:0]  cmdLength,
    output logic [CNT_WIDTH-1:0]  cntDataOut,
    output logic                  cntLoad,
    output logic                  cntClockEnable,
    input  logic                  cntBusy,
    output logic [CHAN_WIDTH-1:0] chanSel,
    output logic                  chanEnable,
    output logic                  serialOut,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned WD_WIDTH = CNT_WIDTH + 1;
    localparam logic [WD_WIDTH-1:0] WD_LAST = WD_WIDTH'(watchdogLast(CNT_WIDTH));

    mux_state_e           state;
    logic [CNT_WIDTH-1:0] lenQ;
    logic [WD_WIDTH-1:0]  wdCount;
    logic                 accept;
    logic                 enterDone;
    logic                 errorHit;
    logic                 shShift;
    logic                 shMsb;

    assign accept  = (state == ST_IDLE) && cmdValid && cmdReady;
    assign shShift = (state == ST_SHIFT) && !enterDone;

    // Every path into DONE is decided here so the registered DONE outputs
    // are written in one place.
    always_comb begin
        errorHit  = 1'b0;
        enterDone = 1'b0;
        case (state)
            ST_ARM: begin
                errorHit  = (cntBusy != (lenQ != '0));
                enterDone = errorHit || (lenQ == '0);
            end
            ST_SHIFT: begin
                errorHit  = cntBusy && (wdCount == WD_LAST);
                enterDone = !cntBusy || errorHit;
            end
            default: begin
                errorHit  = 1'b0;
                enterDone = 1'b0;
            end
        endcase
    end

    mux_shift_reg #(
        .WIDTH (DATA_WIDTH)
    ) uShiftReg (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .load     (accept),
        .loadData (cmdData),
        .shiftEn  (shShift),
        .msb      (shMsb)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state          <= ST_IDLE;
            lenQ           <= '0;
            wdCount        <= '0;
            cmdReady       <= 1'b1;
            cntDataOut     <= '0;
            cntLoad        <= 1'b0;
            cntClockEnable <= 1'b0;
            chanSel        <= '0;
            chanEnable     <= 1'b0;
            serialOut      <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
        end else begin
            if (errorHit) begin
                error <= 1'b1;
            end
            if (enterDone) begin
                state          <= ST_DONE;
                cntClockEnable <= 1'b0;
                chanEnable     <= 1'b0;
                serialOut      <= 1'b0;
                done           <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            state          <= ST_LOAD;
                            lenQ           <= cmdLength;
                            cntDataOut     <= cmdLength;
                            cntLoad        <= 1'b1;
                            cntClockEnable <= 1'b0;
                            chanSel        <= cmdChannel;
                            chanEnable     <= 1'b1;
                            cmdReady       <= 1'b0;
                            error          <= 1'b0;
                        end
                    end
                    ST_LOAD: begin
                        state          <= ST_ARM;
                        cntLoad        <= 1'b0;
                        cntClockEnable <= 1'b1;
                    end
                    ST_ARM: begin
                        state   <= ST_SHIFT;
                        wdCount <= '0;
                    end
                    ST_SHIFT: begin
                        serialOut <= shMsb;
                        wdCount   <= (wdCount == '1) ? wdCount : wdCount + 1'b1;
                    end
                    ST_DONE: begin
                        state    <= ST_IDLE;
                        done     <= 1'b0;
                        cmdReady <= 1'b1;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mux_frame_sequencer.sv
// Directed bench for mux_frame_sequencer with a behavioural bit counter.
// Cycle numbering: the accept cycle is cycle 0; "cN" is N clocks later.
module tb_mux_frame_sequencer;
    import mux_pkg::*;

    localparam int unsigned CNT_W  = 3;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CHAN_W = 4;

    logic              CLK;
    logic              RSTn;
    logic              cmdValid;
    logic              cmdReady;
    logic [CHAN_W-1:0] cmdChannel;
    logic [DATA_W-1:0] cmdData;
    logic [CNT_W-1:0]  cmdLength;
    logic [CNT_W-1:0]  cntDataOut;
    logic              cntLoad;
    logic              cntClockEnable;
    logic              cntBusy;
    logic [CHAN_W-1:0] chanSel;
    logic              chanEnable;
    logic              serialOut;
    logic              done;
    logic              error;

    int nVec = 0;
    int nMis = 0;

    // 0: counter model drives busy, 1: busy forced 0, 2: busy forced 1
    logic [1:0]       busyMode;
    logic [CNT_W-1:0] mCnt;
    logic             mBusy;

    mux_frame_sequencer #(
        .CNT_WIDTH  (CNT_W),
        .DATA_WIDTH (DATA_W),
        .CHAN_WIDTH (CHAN_W)
    ) dut (
        .CLK            (CLK),
        .RSTn           (RSTn),
        .cmdValid       (cmdValid),
        .cmdReady       (cmdReady),
        .cmdChannel     (cmdChannel),
        .cmdData        (cmdData),
        .cmdLength      (cmdLength),
        .cntDataOut     (cntDataOut),
        .cntLoad        (cntLoad),
        .cntClockEnable (cntClockEnable),
        .cntBusy        (cntBusy),
        .chanSel        (chanSel),
        .chanEnable     (chanEnable),
        .serialOut      (serialOut),
        .done           (done),
        .error          (error)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Bit counter: busy is registered and trails the count by one clock,
    // so it stays high for exactly `length` SHIFT cycles after ARM.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            mCnt  <= '0;
            mBusy <= 1'b0;
        end else if (cntLoad) begin
            mCnt  <= cntDataOut;
            mBusy <= (cntDataOut != '0);
        end else if (cntClockEnable) begin
            if (mCnt != '0) mCnt <= mCnt - 1'b1;
            mBusy <= (mCnt != '0);
        end else begin
            mCnt  <= '0;
            mBusy <= 1'b0;
        end
    end

    assign cntBusy = (busyMode == 2'd1) ? 1'b0 :
                     (busyMode == 2'd2) ? 1'b1 : mBusy;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nMis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input MUX_CMD_T c);
        cmdChannel = c.chan;
        cmdData    = c.data;
        cmdLength  = c.length;
        cmdValid   = 1'b1;
    endtask

    MUX_CMD_T  cmd;
    logic [6:0] pat7;
    logic [6:0] patWd;
    int         cyc;

    initial begin
        RSTn       = 1'b0;
        cmdValid   = 1'b0;
        cmdChannel = '0;
        cmdData    = '0;
        cmdLength  = '0;
        busyMode   = 2'd0;
        tick(2);

        // Reset values
        check("rst.cmdReady", 32'(cmdReady), 32'd1);
        check("rst.cntLoad", 32'(cntLoad), 32'd0);
        check("rst.cntClockEnable", 32'(cntClockEnable), 32'd0);
        check("rst.chanEnable", 32'(chanEnable), 32'd0);
        check("rst.chanSel", 32'(chanSel), 32'd0);
        check("rst.cntDataOut", 32'(cntDataOut), 32'd0);
        check("rst.serialOut", 32'(serialOut), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.error", 32'(error), 32'd0);
        RSTn = 1'b1;
        tick();

        // ch=5 data=A5 len=3: bits 1,0,1 then done in c7
        cmd = '{chan: 4'd5, data: 8'hA5, length: 3'd3};
        issue(cmd);
        tick();
        cmdValid = 1'b0;
        check("f3.c1.cmdReady", 32'(cmdReady), 32'd0);
        check("f3.c1.cntLoad", 32'(cntLoad), 32'd1);
        check("f3.c1.cntDataOut", 32'(cntDataOut), 32'd3);
        check("f3.c1.chanSel", 32'(chanSel), 32'd5);
        check("f3.c1.chanEnable", 32'(chanEnable), 32'd1);
        check("f3.c1.cntClockEnable", 32'(cntClockEnable), 32'd0);
        tick();
        check("f3.c2.cntLoad", 32'(cntLoad), 32'd0);
        check("f3.c2.cntClockEnable", 32'(cntClockEnable), 32'd1);
        tick();
        check("f3.c3.serialOut", 32'(serialOut), 32'd0);
        tick();
        check("f3.c4.serialOut", 32'(serialOut), 32'd1);
        tick();
        check("f3.c5.serialOut", 32'(serialOut), 32'd0);
        tick();
        check("f3.c6.serialOut", 32'(serialOut), 32'd1);
        check("f3.c6.done", 32'(done), 32'd0);
        tick();
        check("f3.c7.done", 32'(done), 32'd1);
        check("f3.c7.serialOut", 32'(serialOut), 32'd0);
        check("f3.c7.chanEnable", 32'(chanEnable), 32'd0);
        check("f3.c7.cntClockEnable", 32'(cntClockEnable), 32'd0);
        check("f3.c7.error", 32'(error), 32'd0);
        check("f3.c7.cmdReady", 32'(cmdReady), 32'd0);
        tick();
        check("f3.c8.done", 32'(done), 32'd0);
        check("f3.c8.cmdReady", 32'(cmdReady), 32'd1);

        // len=0: no bits, done in c3, chanEnable high in c1,c2 only
        cmd = '{chan: 4'd2, data: 8'hFF, length: 3'd0};
        issue(cmd);
        tick();
        cmdValid = 1'b0;
        check("f0.c1.chanEnable", 32'(chanEnable), 32'd1);
        check("f0.c1.cntDataOut", 32'(cntDataOut), 32'd0);
        tick();
        check("f0.c2.chanEnable", 32'(chanEnable), 32'd1);
        check("f0.c2.serialOut", 32'(serialOut), 32'd0);
        check("f0.c2.done", 32'(done), 32'd0);
        tick();
        check("f0.c3.done", 32'(done), 32'd1);
        check("f0.c3.chanEnable", 32'(chanEnable), 32'd0);
        check("f0.c3.serialOut", 32'(serialOut), 32'd0);
        check("f0.c3.error", 32'(error), 32'd0);
        tick();
        check("f0.c4.cmdReady", 32'(cmdReady), 32'd1);
        check("f0.c4.done", 32'(done), 32'd0);

        // len=4 with busy low in ARM: error + done in c3, error sticky
        busyMode = 2'd1;
        cmd = '{chan: 4'd4, data: 8'h0F, length: 3'd4};
        issue(cmd);
        tick();
        cmdValid = 1'b0;
        tick(2);
        check("mis.c3.done", 32'(done), 32'd1);
        check("mis.c3.error", 32'(error), 32'd1);
        tick();
        check("mis.c4.error", 32'(error), 32'd1);
        check("mis.c4.cmdReady", 32'(cmdReady), 32'd1);
        // busy glitching high in IDLE changes nothing
        busyMode = 2'd2;
        tick(2);
        check("idle.glitch.cmdReady", 32'(cmdReady), 32'd1);
        check("idle.glitch.cntLoad", 32'(cntLoad), 32'd0);
        check("idle.glitch.chanEnable", 32'(chanEnable), 32'd0);
        check("idle.glitch.error", 32'(error), 32'd1);
        busyMode = 2'd0;
        // next accept clears the error; len=1 data=80 sends a single 1
        cmd = '{chan: 4'd9, data: 8'h80, length: 3'd1};
        issue(cmd);
        tick();
        cmdValid = 1'b0;
        check("clr.c1.error", 32'(error), 32'd0);
        check("clr.c1.chanSel", 32'(chanSel), 32'd9);
        tick(3);
        check("clr.c4.serialOut", 32'(serialOut), 32'd1);
        tick();
        check("clr.c5.done", 32'(done), 32'd1);
        check("clr.c5.error", 32'(error), 32'd0);
        tick();

        // busy stuck high, len=2: watchdog ends SHIFT after 8 cycles (c3..c10)
        busyMode = 2'd2;
        cmd = '{chan: 4'd3, data: 8'hC3, length: 3'd2};
        issue(cmd);
        tick();
        cmdValid = 1'b0;
        patWd = 7'b1100001;
        tick(3);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("wd.c%0d.serialOut", i + 4), 32'(serialOut), 32'(patWd[6 - i]));
            if (i < 6) tick();
        end
        check("wd.c10.done", 32'(done), 32'd0);
        check("wd.c10.chanEnable", 32'(chanEnable), 32'd1);
        tick();
        check("wd.c11.done", 32'(done), 32'd1);
        check("wd.c11.error", 32'(error), 32'd1);
        busyMode = 2'd0;
        tick();
        check("wd.c12.cmdReady", 32'(cmdReady), 32'd1);

        // len=7 (maximum): the 7 MSBs of B5 in c4..c10, done in c11
        cmd = '{chan: 4'd15, data: 8'hB5, length: 3'd7};
        issue(cmd);
        tick();
        cmdValid = 1'b0;
        pat7 = 7'b1011010;
        tick(3);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("max.c%0d.serialOut", i + 4), 32'(serialOut), 32'(pat7[6 - i]));
            tick();
        end
        check("max.c11.done", 32'(done), 32'd1);
        check("max.c11.error", 32'(error), 32'd0);
        tick();

        // back-to-back with cmdValid held: second accept in the cycle after done
        cmd = '{chan: 4'd1, data: 8'h40, length: 3'd1};
        issue(cmd);
        tick();
        check("b2b.c1.cntLoad", 32'(cntLoad), 32'd1);
        cmd = '{chan: 4'd10, data: 8'h80, length: 3'd2};
        issue(cmd);
        for (int i = 2; i <= 6; i++) begin
            tick();
            check($sformatf("b2b.c%0d.cntLoad", i), 32'(cntLoad), 32'd0);
            if (i == 5) check("b2b.c5.done", 32'(done), 32'd1);
            if (i == 6) check("b2b.c6.cmdReady", 32'(cmdReady), 32'd1);
        end
        tick();
        cmdValid = 1'b0;
        check("b2b.c7.cntLoad", 32'(cntLoad), 32'd1);
        check("b2b.c7.cntDataOut", 32'(cntDataOut), 32'd2);
        check("b2b.c7.chanSel", 32'(chanSel), 32'd10);
        cyc = 1;
        while (!done && cyc < 20) begin
            tick();
            cyc++;
        end
        check("b2b.second.doneCycle", 32'(cyc), 32'd6);
        tick(2);

        // reset in the middle of SHIFT
        cmd = '{chan: 4'd7, data: 8'hFE, length: 3'd7};
        issue(cmd);
        tick();
        cmdValid = 1'b0;
        tick(3);
        check("rmid.pre.chanEnable", 32'(chanEnable), 32'd1);
        check("rmid.pre.cntClockEnable", 32'(cntClockEnable), 32'd1);
        check("rmid.pre.serialOut", 32'(serialOut), 32'd1);
        #2;
        RSTn = 1'b0;
        #1;
        check("rmid.async.chanEnable", 32'(chanEnable), 32'd0);
        check("rmid.async.cntClockEnable", 32'(cntClockEnable), 32'd0);
        check("rmid.async.serialOut", 32'(serialOut), 32'd0);
        check("rmid.async.done", 32'(done), 32'd0);
        RSTn = 1'b1;
        tick();
        check("rmid.post.cmdReady", 32'(cmdReady), 32'd1);
        check("rmid.post.done", 32'(done), 32'd0);
        check("rmid.post.chanEnable", 32'(chanEnable), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
